// File: rtl/t_decode_pkg.sv
// Shared types and defaults for the toggle-line receiver.
package t_decode_pkg;

    // Receiver control states: prime the reference level, then detect changes
    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_PEND_W      = 4;

    // Priming lasts long enough for the synchroniser to flush plus one
    // cycle to load the reference level from a settled value.
    function automatic int prime_len(input int sync_stages);
        return sync_stages + 1;
    endfunction

endpackage

// File: rtl/t_sync.sv
// Multi-flop synchroniser bringing an asynchronous level into clk.
module t_sync
    import t_decode_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rest,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk) begin
        if (rest) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule

// File: rtl/t_decode.sv
// Toggle-line receiver: turns each level change of a remote T flip-flop
// output into a one-cycle local pulse, counts events, and queues them in a
// saturating pending counter behind a valid/ready handshake.
// Optional feature macro: T_DECODE_GLITCH_FILTER_EN (a new level must be
// seen for two consecutive cycles before it counts as a transition).
module t_decode
    import t_decode_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int PEND_W      = DEF_PEND_W
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              q_in,
    input  logic              en,
    output logic              t_out,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [CNT_W-1:0]  ev_count,
    output logic [PEND_W-1:0] pending,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam int                PRIME_LEN = prime_len(SYNC_STAGES);
    localparam int                PC_W      = $clog2(PRIME_LEN + 1);
    localparam logic [PEND_W-1:0] PEND_FULL = '1;

    logic              w_sync;
    logic              w_change;
    logic              w_accept;
    logic              w_pop;
    logic              w_full;
    logic              w_drop;
    logic [PEND_W-1:0] w_pend_nxt;

    state_t            r_state;
    logic [PC_W-1:0]   r_prime_cnt;
    logic              r_ref;
    logic              r_t_out;
    logic              r_ev_valid;
    logic [CNT_W-1:0]  r_ev_count;
    logic [PEND_W-1:0] r_pending;
    logic              r_overflow;

    t_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rest (rest),
        .d    (q_in),
        .q    (w_sync)
    );

`ifdef T_DECODE_GLITCH_FILTER_EN
    logic r_cand;

    // Remember last cycle's synchronised level so a change must persist
    always_ff @(posedge clk) begin
        if (rest) begin
            r_cand <= 1'b0;
        end else begin
            r_cand <= w_sync;
        end
    end

    assign w_change = (w_sync != r_ref) && (w_sync == r_cand);
`else
    assign w_change = (w_sync != r_ref);
`endif

    assign w_accept = (r_state == ST_RUN) && w_change && en;
    assign w_pop    = r_ev_valid && ev_ready;
    assign w_full   = (r_pending == PEND_FULL);
    // A pop in the same cycle frees the slot, so only a lone accept drops
    assign w_drop   = w_accept && !w_pop && w_full;

    // Next pending count: saturating increment on accept, decrement on pop
    always_comb begin
        w_pend_nxt = r_pending;
        if (w_accept && !w_pop && !w_full) begin
            w_pend_nxt = r_pending + PEND_W'(1);
        end else if (!w_accept && w_pop) begin
            w_pend_nxt = r_pending - PEND_W'(1);
        end
    end

    // Control FSM, reference level tracking and all registered outputs
    always_ff @(posedge clk) begin
        if (rest) begin
            r_state     <= ST_PRIME;
            r_prime_cnt <= '0;
            r_ref       <= 1'b0;
            r_t_out     <= 1'b0;
            r_ev_valid  <= 1'b0;
            r_ev_count  <= '0;
            r_pending   <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_t_out    <= w_accept;
            r_pending  <= w_pend_nxt;
            // ev_valid is derived from the next count so it never depends
            // combinationally on ev_ready
            r_ev_valid <= (w_pend_nxt != '0);

            if (w_accept) begin
                r_ev_count <= r_ev_count + CNT_W'(1);
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end

            case (r_state)
                ST_PRIME: begin
                    r_ref <= w_sync;
                    if (r_prime_cnt == PC_W'(PRIME_LEN - 1)) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_prime_cnt <= r_prime_cnt + PC_W'(1);
                    end
                end
                ST_RUN: begin
                    // Reference follows every change, accepted or not, so a
                    // disabled period never replays later
                    if (w_change) begin
                        r_ref <= w_sync;
                    end
                end
                default: begin
                    r_state <= ST_PRIME;
                end
            endcase
        end
    end

    assign t_out    = r_t_out;
    assign ev_valid = r_ev_valid;
    assign ev_count = r_ev_count;
    assign pending  = r_pending;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_t_decode.sv
// Bench for t_decode: directed sequences, a segment table and a randomized
// run compared against an event-level reference model.
module tb_t_decode;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 8;
    localparam int PEND_W      = 4;
    localparam int PEND_MAX    = (1 << PEND_W) - 1;
`ifdef T_DECODE_GLITCH_FILTER_EN
    localparam int LAT  = SYNC_STAGES + 1;
    localparam bit FILT = 1'b1;
`else
    localparam int LAT  = SYNC_STAGES;
    localparam bit FILT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rest;
    logic              q_in;
    logic              en;
    logic              t_out;
    logic              ev_valid;
    logic              ev_ready;
    logic [CNT_W-1:0]  ev_count;
    logic [PEND_W-1:0] pending;
    logic              overflow;
    logic              clr_ovf;

    always #5 clk = ~clk;

    t_decode #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W),
        .PEND_W      (PEND_W)
    ) dut (
        .clk      (clk),
        .rest     (rest),
        .q_in     (q_in),
        .en       (en),
        .t_out    (t_out),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_count (ev_count),
        .pending  (pending),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;

    typedef struct {
        int ntog;
        int gap;
        bit en;
        bit rdy;
        bit clr;
        int settle;
        int exp_pulses;
        int exp_count;
        int exp_pend;
        bit exp_valid;
        bit exp_ovf;
    } seg_t;

    seg_t segs[7];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (t_out) pulses++;
    endtask

    task automatic toggle();
        q_in = ~q_in;
    endtask

    // reference model state for the randomized run
    bit hist[$];
    int m_cnt, m_pend;
    bit m_ovf, m_t;

    task automatic model_reset();
        hist.delete();
        m_cnt  = 0;
        m_pend = 0;
        m_ovf  = 1'b0;
        m_t    = 1'b0;
    endtask

    // One clock edge of the event-level model: a level change first sampled
    // at edge k is reported at edge k+LAT (if enabled at that edge).
    task automatic model_edge();
        int e;
        bit evt, acc, pop, drop;
        hist.push_back(q_in);
        e    = hist.size() - 1;
        evt  = (e >= LAT + 1) && (hist[e-LAT] != hist[e-LAT-1]);
        acc  = evt && en;
        pop  = (m_pend != 0) && ev_ready;
        drop = 1'b0;
        if (acc && !pop) begin
            if (m_pend == PEND_MAX) drop = 1'b1;
            else m_pend++;
        end else if (pop && !acc) begin
            m_pend--;
        end
        if (acc) m_cnt = (m_cnt + 1) % (1 << CNT_W);
        if (drop) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
        m_t = acc;
    endtask

    initial begin
        int first;
        bit pv;
        int hold;

        segs[0] = '{12, 3, 1'b1, 1'b0, 1'b0,  8, 12, 15, 15, 1'b1, 1'b0};
        segs[1] = '{ 2, 3, 1'b1, 1'b0, 1'b0,  8,  2, 17, 15, 1'b1, 1'b1};
        segs[2] = '{ 0, 3, 1'b1, 1'b0, 1'b1,  2,  0, 17, 15, 1'b1, 1'b0};
        segs[3] = '{ 2, 4, 1'b0, 1'b0, 1'b0,  8,  0, 17, 15, 1'b1, 1'b0};
        segs[4] = '{ 0, 3, 1'b1, 1'b0, 1'b0,  8,  0, 17, 15, 1'b1, 1'b0};
        segs[5] = '{ 0, 3, 1'b1, 1'b1, 1'b0, 20,  0, 17,  0, 1'b0, 1'b0};
        segs[6] = '{ 3, 4, 1'b1, 1'b1, 1'b0,  8,  3, 20,  0, 1'b0, 1'b0};

        rest     = 1'b1;
        q_in     = 1'b1;
        en       = 1'b1;
        ev_ready = 1'b0;
        clr_ovf  = 1'b0;

        // reset with q_in held high, then no spurious event
        repeat (3) tick();
        check("reset_outputs", int'({t_out, ev_valid, overflow, pending, ev_count}), 0);
        rest   = 1'b0;
        pulses = 0;
        repeat (10) tick();
        check("no_spurious_pulse", pulses, 0);
        check("no_spurious_count", int'(ev_count), 0);
        check("no_spurious_pending", int'(pending), 0);

        // three toggles, four cycles apart: exact latency and single pulses
        for (int t = 0; t < 3; t++) begin
            toggle();
            first  = 0;
            pulses = 0;
            for (int i = 1; i <= 4; i++) begin
                pv = ev_valid;
                tick();
                if (t_out && first == 0) begin
                    first = i;
                    if (t == 0) begin
                        check("valid_before_first", int'(pv), 0);
                        check("valid_with_first", int'(ev_valid), 1);
                    end
                end
            end
            check($sformatf("latency_%0d", t), first, LAT + 1);
            check($sformatf("pulse_count_%0d", t), pulses, 1);
        end
        pulses = 0;
        repeat (4) tick();
        check("no_trailing_pulse", pulses, 0);
        check("three_count", int'(ev_count), 3);
        check("three_pending", int'(pending), 3);
        check("three_valid", int'(ev_valid), 1);

        // segment table: fill, overflow, clear, disable, drain, pass-through
        for (int s = 0; s < 7; s++) begin
            en       = segs[s].en;
            ev_ready = segs[s].rdy;
            clr_ovf  = segs[s].clr;
            pulses   = 0;
            for (int n = 0; n < segs[s].ntog; n++) begin
                toggle();
                repeat (segs[s].gap) tick();
            end
            repeat (segs[s].settle) tick();
            clr_ovf = 1'b0;
            check($sformatf("seg%0d_pulses", s), pulses, segs[s].exp_pulses);
            check($sformatf("seg%0d_count", s), int'(ev_count), segs[s].exp_count);
            check($sformatf("seg%0d_pending", s), int'(pending), segs[s].exp_pend);
            check($sformatf("seg%0d_valid", s), int'(ev_valid), int'(segs[s].exp_valid));
            check($sformatf("seg%0d_ovf", s), int'(overflow), int'(segs[s].exp_ovf));
        end
        en       = 1'b1;
        ev_ready = 1'b0;

        // refill to full, overflow, then set and clear in the same cycle
        repeat (15) begin
            toggle();
            repeat (3) tick();
        end
        repeat (6) tick();
        check("refill_pending", int'(pending), 15);
        check("refill_ovf", int'(overflow), 0);
        check("refill_count", int'(ev_count), 35);
        toggle();
        repeat (8) tick();
        check("drop_ovf", int'(overflow), 1);
        check("drop_count", int'(ev_count), 36);
        check("drop_pending", int'(pending), 15);
        toggle();
        repeat (LAT) tick();
        clr_ovf = 1'b1;
        tick();
        check("setwins_tout", int'(t_out), 1);
        check("setwins_ovf", int'(overflow), 1);
        check("setwins_count", int'(ev_count), 37);
        tick();
        clr_ovf = 1'b0;
        check("clr_ovf", int'(overflow), 0);

        // full counter: accept and pop in the same cycle
        toggle();
        repeat (LAT) tick();
        ev_ready = 1'b1;
        tick();
        check("accpop_tout", int'(t_out), 1);
        check("accpop_pending", int'(pending), 15);
        check("accpop_ovf", int'(overflow), 0);
        check("accpop_count", int'(ev_count), 38);
        ev_ready = 1'b0;
        tick();
        check("hold_pending", int'(pending), 15);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        check("pop_pending", int'(pending), 14);

        // single-cycle pulse on q_in
        pulses = 0;
        toggle();
        tick();
        toggle();
        repeat (10) tick();
        check("glitch_pulses", pulses, FILT ? 0 : 2);
        check("glitch_count", int'(ev_count), FILT ? 38 : 40);

        // reset mid-operation discards pending state
        rest = 1'b1;
        q_in = 1'b1;
        repeat (2) tick();
        check("midreset_outputs", int'({t_out, ev_valid, overflow, pending, ev_count}), 0);
        rest   = 1'b0;
        pulses = 0;
        repeat (10) tick();
        check("midreset_pulses", pulses, 0);
        check("midreset_count", int'(ev_count), 0);

        // randomized traffic against the reference model
        for (int blk = 0; blk < 2; blk++) begin
            rest     = 1'b1;
            q_in     = 1'($urandom_range(0, 1));
            en       = 1'b1;
            ev_ready = 1'b0;
            clr_ovf  = 1'b0;
            repeat (2) tick();
            rest = 1'b0;
            model_reset();
            hold = 0;
            for (int c = 0; c < 1500; c++) begin
                if (c >= 10) begin
                    if (hold == 0) begin
                        toggle();
                        hold = $urandom_range(2, 5);
                    end
                    hold--;
                end
                en       = ($urandom_range(0, 7) != 0);
                ev_ready = (blk == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
                clr_ovf  = ($urandom_range(0, 15) == 0);
                @(posedge clk);
                model_edge();
                #1;
                n_cmp++;
                if (t_out !== m_t || ev_valid !== (m_pend != 0) || overflow !== m_ovf ||
                    int'(pending) != m_pend || int'(ev_count) != m_cnt) begin
                    n_bad++;
                    $display("FAIL rand blk%0d cyc%0d: got t=%0d v=%0d ovf=%0d pend=%0d cnt=%0d, expected t=%0d v=%0d ovf=%0d pend=%0d cnt=%0d",
                             blk, c, t_out, ev_valid, overflow, pending, ev_count,
                             m_t, (m_pend != 0), m_ovf, m_pend, m_cnt);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
